// File: rtl/store_tank.sv
// store_tank: bit-serial model of one long mercury delay line (16 minor cycles x 36 digits).
// Transfers a long or short word when the addressed slot passes the tank output.
module store_tank #(
    parameter int MINORS = 16,
    parameter int DIGITS = 36,
    parameter int SHORT  = 18
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       d0,
    input  logic       d35,
    input  logic [4:0] addr,
    input  logic       long_sel,
    input  logic       rd_req,
    input  logic       wr_req,
    input  logic       mob,
    output logic       mib,
    output logic       busy,
    output logic       done,
    output logic [3:0] minor
);

    localparam int BITS = MINORS * DIGITS;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        XFER,
        DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [5:0]        digit_q;
    logic [5:0]        cur_digit;
    logic [3:0]        minor_q;
    logic              op_wr;
    logic              long_q;
    logic [4:0]        addr_q;
    logic [5:0]        cnt;
    logic [5:0]        cnt_next;
    logic [5:0]        start_digit;
    logic [5:0]        last_cnt;
    logic [9:0]        idx;
    logic              slot_hit;
    logic              active;
    logic [BITS-1:0]   mem;

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_q <= '0;
        end else if (d0) begin
            digit_q <= 6'd1;
        end else if (digit_q == 6'(DIGITS - 1)) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_q + 6'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            minor_q <= '0;
        end else if (d35) begin
            minor_q <= minor_q + 4'd1;
        end
    end

    assign cur_digit   = d0 ? 6'd0 : digit_q;
    assign idx         = 10'(minor_q) * 10'(DIGITS) + 10'(cur_digit);
    assign start_digit = (long_q || !addr_q[0]) ? 6'd0 : 6'(SHORT);
    assign last_cnt    = long_q ? 6'(DIGITS - 1) : 6'(SHORT - 1);
    assign slot_hit    = (minor_q == addr_q[4:1]) && (cur_digit == start_digit);

    // The matching WAIT cycle already moves transfer digit 0.
    assign active      = ((state == WAIT) && slot_hit) || (state == XFER);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            IDLE: begin
                if (wr_req || rd_req) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (slot_hit) begin
                    state_next = XFER;
                    cnt_next   = 6'd1;
                end
            end
            XFER: begin
                if (cnt == last_cnt) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt + 6'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Write wins when both requests arrive together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_wr  <= 1'b0;
            long_q <= 1'b0;
            addr_q <= '0;
        end else if ((state == IDLE) && (wr_req || rd_req)) begin
            op_wr  <= wr_req;
            long_q <= long_sel;
            addr_q <= addr;
        end
    end

    // NOTE: the tank contents are deliberately not reset; data survives rst like the real delay line.
    always_ff @(posedge clk) begin
        if (active && op_wr) begin
            mem[idx] <= mob;
        end
    end

    assign mib   = active && !op_wr && mem[idx];
    assign busy  = (state == WAIT) || (state == XFER);
    assign done  = (state == DONE);
    assign minor = minor_q;

endmodule

// File: tb/tb_store_tank.sv
// Self-checking bench for store_tank: table-driven directed transfers, corner sequences and
// random transactions scored against a slot-level model of the 576-bit tank.
module tb_store_tank;

    logic       clk = 1'b0;
    logic       rst;
    logic       d0;
    logic       d35;
    logic [4:0] addr;
    logic       long_sel;
    logic       rd_req;
    logic       wr_req;
    logic       mob;
    logic       mib;
    logic       busy;
    logic       done;
    logic [3:0] minor;

    store_tank dut (
        .clk      (clk),
        .rst      (rst),
        .d0       (d0),
        .d35      (d35),
        .addr     (addr),
        .long_sel (long_sel),
        .rd_req   (rd_req),
        .wr_req   (wr_req),
        .mob      (mob),
        .mib      (mib),
        .busy     (busy),
        .done     (done),
        .minor    (minor)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [4:0]  a;
        bit          lng;
        logic [35:0] data;   // write data, or expected read data
    } vec_t;

    vec_t tbl[12];
    bit   ref_mem[576];      // model of the tank, indexed by minor*36 + digit
    int   slot;              // tank position of the current cycle
    int   vectors;
    int   miscompares;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic check_cycle(input string name, input logic eb, input logic ed, input logic em);
        check(name, {57'd0, busy, done, mib, minor}, {57'd0, eb, ed, em, 4'(slot / 36)});
    endtask

    task automatic begin_cycle();
        @(negedge clk);
        d0  = (slot % 36 == 0);
        d35 = (slot % 36 == 35);
    endtask

    task automatic end_cycle();
        @(posedge clk);
        slot = (slot + 1) % 576;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; rd_req = 1'b0; wr_req = 1'b0; mob = 1'b0; d0 = 1'b0; d35 = 1'b0;
        #1 check("reset outputs", {57'd0, busy, done, mib, minor}, 64'd0);
        @(negedge clk);
        #1 check("reset held", {57'd0, busy, done, mib, minor}, 64'd0);
        rst  = 1'b0;
        slot = 0;
        d0   = 1'b1;
        d35  = 1'b0;
        @(posedge clk);
        slot = 1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            begin_cycle();
            rd_req = 1'b0; wr_req = 1'b0; addr = 5'($urandom);
            #1 check_cycle("idle", 1'b0, 1'b0, 1'b0);
            end_cycle();
        end
    endtask

    // One complete transaction with per-cycle checking against the slot schedule.
    task automatic run_txn(input bit wr, input bit both, input logic [4:0] a, input bit lng,
                           input logic [35:0] wdata, input int issue_slot, input bit noise,
                           input int abort_after, output logic [35:0] rdata, output int busy_cnt);
        int len;
        int start;
        int p;
        int delta;
        bit is_wr;
        len   = lng ? 36 : 18;
        start = int'(a[4:1]) * 36 + ((lng || !a[0]) ? 0 : 18);
        is_wr = wr || both;
        rdata = '0;
        busy_cnt = 0;
        if (issue_slot >= 0) begin
            while (slot != issue_slot) idle(1);
        end
        begin_cycle();
        p = slot;
        addr = a; long_sel = lng; wr_req = is_wr; rd_req = !wr || both;
        #1 check_cycle("accept", 1'b0, 1'b0, 1'b0);
        end_cycle();
        delta = ((start - p - 1) % 576 + 576) % 576 + 1;
        for (int k = 1; k < delta; k++) begin
            begin_cycle();
            rd_req = noise ? 1'($urandom) : 1'b0;
            wr_req = noise ? 1'($urandom) : 1'b0;
            addr = 5'($urandom); long_sel = 1'($urandom); mob = 1'($urandom);
            #1 check_cycle("wait", 1'b1, 1'b0, 1'b0);
            busy_cnt += int'(busy);
            end_cycle();
        end
        for (int i = 0; i < len; i++) begin
            if (i == abort_after) begin
                apply_reset();
                return;
            end
            begin_cycle();
            rd_req = noise ? 1'($urandom) : 1'b0;
            wr_req = noise ? 1'($urandom) : 1'b0;
            mob = is_wr ? wdata[i] : 1'($urandom);
            #1 check_cycle("xfer", 1'b1, 1'b0, is_wr ? 1'b0 : ref_mem[start + i]);
            rdata[i] = mib;
            busy_cnt += int'(busy);
            if (is_wr) ref_mem[start + i] = wdata[i];
            end_cycle();
        end
        begin_cycle();
        rd_req = 1'b0; wr_req = 1'b0; mob = 1'b0;
        #1 check_cycle("done", 1'b0, 1'b1, 1'b0);
        end_cycle();
        idle(1);
    endtask

    initial begin
        logic [35:0] rd;
        logic [35:0] data;
        logic [35:0] mask;
        int          bc;
        int          m;
        bit          w;
        bit          lng;

        vectors = 0; miscompares = 0; slot = 0;
        rst = 1'b1; d0 = 1'b0; d35 = 1'b0; addr = '0; long_sel = 1'b0;
        rd_req = 1'b0; wr_req = 1'b0; mob = 1'b0;

        tbl[0]  = '{1'b1, 5'd6,  1'b1, 36'h0_0000_0005};
        tbl[1]  = '{1'b0, 5'd6,  1'b1, 36'h0_0000_0005};
        tbl[2]  = '{1'b1, 5'd9,  1'b0, 36'h0_0002_A5A5};
        tbl[3]  = '{1'b1, 5'd8,  1'b0, 36'h0_0000_0001};
        tbl[4]  = '{1'b0, 5'd9,  1'b0, 36'h0_0002_A5A5};
        tbl[5]  = '{1'b0, 5'd8,  1'b0, 36'h0_0000_0001};
        tbl[6]  = '{1'b0, 5'd7,  1'b1, 36'h0_0000_0005};
        tbl[7]  = '{1'b1, 5'd31, 1'b1, 36'hF_0F0F_1234};
        tbl[8]  = '{1'b0, 5'd31, 1'b1, 36'hF_0F0F_1234};
        tbl[9]  = '{1'b1, 5'd31, 1'b0, 36'h0_0003_FFFF};
        tbl[10] = '{1'b0, 5'd30, 1'b0, 36'h0_0003_1234};
        tbl[11] = '{1'b0, 5'd31, 1'b1, 36'hF_FFFF_1234};

        apply_reset();

        // Give every word a known value: even minors first, then odd ones.
        for (int k = 0; k < 16; k++) begin
            m    = (k < 8) ? 2 * k : 2 * (k - 8) + 1;
            data = 36'({$urandom, $urandom});
            run_txn(1'b1, 1'b0, {4'(m), 1'b0}, 1'b1, data, -1, 1'b0, -1, rd, bc);
        end

        for (int i = 0; i < 12; i++) begin
            run_txn(tbl[i].wr, 1'b0, tbl[i].a, tbl[i].lng, tbl[i].data, -1, 1'b0, -1, rd, bc);
            if (!tbl[i].wr) begin
                mask = tbl[i].lng ? 36'hF_FFFF_FFFF : 36'h0_0003_FFFF;
                check($sformatf("table rdata %0d", i), 64'(rd & mask), 64'(tbl[i].data & mask));
            end
        end

        // Both requests together: must be a write.
        run_txn(1'b0, 1'b1, 5'd20, 1'b1, 36'hA_5C3C_96E1, -1, 1'b0, -1, rd, bc);
        run_txn(1'b0, 1'b0, 5'd20, 1'b1, '0, -1, 1'b0, -1, rd, bc);
        check("priority rdata", 64'(rd), 64'(36'hA_5C3C_96E1));

        // Requests toggling during WAIT/XFER are ignored and never queued.
        run_txn(1'b0, 1'b0, 5'd12, 1'b1, '0, -1, 1'b1, -1, rd, bc);

        // Read of addr 0 issued one cycle after minor 0 digit 0.
        run_txn(1'b0, 1'b0, 5'd0, 1'b1, '0, 1, 1'b0, -1, rd, bc);
        check("latency busy cycles", 64'(bc), 64'd610);

        // Reset after 10 digits of an all-ones write over zeros.
        run_txn(1'b1, 1'b0, 5'd10, 1'b1, '0, -1, 1'b0, -1, rd, bc);
        run_txn(1'b1, 1'b0, 5'd10, 1'b1, 36'hF_FFFF_FFFF, -1, 1'b0, 10, rd, bc);
        run_txn(1'b0, 1'b0, 5'd10, 1'b1, '0, -1, 1'b0, -1, rd, bc);
        check("abort rdata", 64'(rd), 64'(36'h0_0000_03FF));

        for (int n = 0; n < 24; n++) begin
            w    = 1'($urandom);
            lng  = 1'($urandom);
            data = 36'({$urandom, $urandom});
            idle($urandom_range(0, 20));
            run_txn(w, 1'b0, 5'($urandom), lng, data, -1, 1'($urandom), -1, rd, bc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
